// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: debounced buttons, reversal-safe direction, game tick.
// Optional pause button/toggle enabled by defining SNAKE_PAUSE_EN.
module snake_dir_ctrl #(
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned TICK_CYCLES = 4194304,
  parameter int unsigned CLEAR_LEAD  = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_button,
  input  logic       down_button,
  input  logic       left_button,
  input  logic       right_button,
`ifdef SNAKE_PAUSE_EN
  input  logic       pause_button,
  output logic       paused,
`endif
  output logic       dir_up,
  output logic       dir_down,
  output logic       dir_left,
  output logic       dir_right,
  output logic       tick,
  output logic       clear_pulse,
  output logic [3:0] btn_pressed
);

`ifdef SNAKE_PAUSE_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TW  = $clog2(TICK_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  T_MAX  = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0]  C_AT   = TW'(TICK_CYCLES - 1 - CLEAR_LEAD);

  logic [NB-1:0]           raw_n, act, ev;
  logic [NB-1:0]           s1_q, s2_q;
  logic [NB-1:0]           lvl_q, lvl_d, prv_q;
  logic [NB-1:0][DBW-1:0]  dbc_q, dbc_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic                    tick_q, tick_d;
  logic                    clr_q, clr_d;
  logic [3:0]              dir_q, dir_d;
  logic [3:0]              pend_q, pend_d;
  logic [3:0]              win, opp;
  logic                    run;

`ifdef SNAKE_PAUSE_EN
  logic pause_q, pause_d;
  assign raw_n   = {pause_button, up_button, down_button,
                    left_button, right_button};
  assign pause_d = pause_q ^ ev[4];
  assign run     = ~pause_q;
  assign paused  = pause_q;

  always_ff @(posedge clk) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause_d;
  end
`else
  assign raw_n = {up_button, down_button, left_button, right_button};
  assign run   = 1'b1;
`endif

  // buttons are active-low; debounce operates on the pressed level
  assign act = ~s2_q;
  assign ev  = lvl_q & ~prv_q;

  always_comb begin
    lvl_d = lvl_q;
    dbc_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (act[i] != lvl_q[i]) begin
        if (dbc_q[i] == DB_MAX) lvl_d[i] = act[i];
        else dbc_d[i] = dbc_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    win = 4'b0000;
    if (ev[3])      win = 4'b1000;
    else if (ev[2]) win = 4'b0100;
    else if (ev[1]) win = 4'b0010;
    else if (ev[0]) win = 4'b0001;
  end

  assign opp = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};

  always_comb begin
    pend_d = pend_q;
    if (win != 4'b0000 && win != opp) pend_d = win;
  end

  // commit uses the pre-edge pending value, so a coincident press waits a tick
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    clr_d  = 1'b0;
    dir_d  = dir_q;
    if (run) begin
      cnt_d  = (cnt_q == T_MAX) ? '0 : cnt_q + 1'b1;
      tick_d = (cnt_q == T_MAX);
      clr_d  = (cnt_q == C_AT);
      if (cnt_q == T_MAX) dir_d = pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      lvl_q  <= '0;
      prv_q  <= '0;
      dbc_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      clr_q  <= 1'b0;
      dir_q  <= 4'b0001;
      pend_q <= 4'b0001;
    end else begin
      s1_q   <= raw_n;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      prv_q  <= lvl_q;
      dbc_q  <= dbc_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      clr_q  <= clr_d;
      dir_q  <= dir_d;
      pend_q <= pend_d;
    end
  end

  assign dir_up      = dir_q[3];
  assign dir_down    = dir_q[2];
  assign dir_left    = dir_q[1];
  assign dir_right   = dir_q[0];
  assign tick        = tick_q;
  assign clear_pulse = clr_q;
  assign btn_pressed = lvl_q[3:0];

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed self-checking bench for snake_dir_ctrl.
// DB_CYCLES=4, TICK_CYCLES=16, CLEAR_LEAD=3; pause scenario under SNAKE_PAUSE_EN.
module tb_snake_dir_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up_button = 1'b1;
  logic down_button = 1'b1;
  logic left_button = 1'b1;
  logic right_button = 1'b1;
  logic dir_up, dir_down, dir_left, dir_right;
  logic tick, clear_pulse;
  logic [3:0] btn_pressed;
`ifdef SNAKE_PAUSE_EN
  logic pause_button = 1'b1;
  logic paused;
`endif

  int checks = 0;
  int passes = 0;
  int n = 0;

  wire [3:0] dir = {dir_up, dir_down, dir_left, dir_right};

  snake_dir_ctrl #(
    .DB_CYCLES(4),
    .TICK_CYCLES(16),
    .CLEAR_LEAD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .up_button(up_button),
    .down_button(down_button),
    .left_button(left_button),
    .right_button(right_button),
`ifdef SNAKE_PAUSE_EN
    .pause_button(pause_button),
    .paused(paused),
`endif
    .dir_up(dir_up),
    .dir_down(dir_down),
    .dir_left(dir_left),
    .dir_right(dir_right),
    .tick(tick),
    .clear_pulse(clear_pulse),
    .btn_pressed(btn_pressed)
  );

  always #5 clk = ~clk;

  // n counts falling edges since reset was released on a falling edge
  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic wait_to(input int t);
    while (n < t) step();
  endtask

  task automatic set_btn(input logic [3:0] v);
    up_button    = ~v[3];
    down_button  = ~v[2];
    left_button  = ~v[1];
    right_button = ~v[0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    checks++;
    if (dir !== 4'b0001)
      $display("FAIL reset_dir got=%b exp=0001", dir);
    else passes++;
    checks++;
    if ({tick, clear_pulse} !== 2'b00)
      $display("FAIL reset_tick got=%b exp=00", {tick, clear_pulse});
    else passes++;
    checks++;
    if (btn_pressed !== 4'b0000)
      $display("FAIL reset_btn got=%b exp=0000", btn_pressed);
    else passes++;
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_tick();
    while (n < 48) begin
      step();
      checks++;
      if (tick !== (n % 16 == 0) || clear_pulse !== (n % 16 == 13))
        $display("FAIL tick_clear n=%0d got=%b%b exp=%b%b", n,
                 tick, clear_pulse, (n % 16 == 0), (n % 16 == 13));
      else passes++;
    end
    checks++;
    if (dir !== 4'b0001) $display("FAIL idle_dir got=%b exp=0001", dir);
    else passes++;
  endtask

  task automatic test_debounce();
    set_btn(4'b0100);
    wait_to(51);
    set_btn(4'b0000);
    while (n < 64) begin
      step();
      checks++;
      if (btn_pressed !== 4'b0000)
        $display("FAIL short_glitch n=%0d got=%b exp=0000", n, btn_pressed);
      else passes++;
    end
    checks++;
    if (dir !== 4'b0001 || tick !== 1'b1)
      $display("FAIL glitch_dir got=%b t=%b exp=0001 t=1", dir, tick);
    else passes++;
    set_btn(4'b0100);
    wait_to(69);
    checks++;
    if (btn_pressed !== 4'b0000)
      $display("FAIL db_early got=%b exp=0000", btn_pressed);
    else passes++;
    step();
    checks++;
    if (btn_pressed !== 4'b0100)
      $display("FAIL db_level got=%b exp=0100", btn_pressed);
    else passes++;
    wait_to(74);
    set_btn(4'b0000);
    wait_to(79);
    checks++;
    if (dir !== 4'b0001)
      $display("FAIL pre_tick_dir got=%b exp=0001", dir);
    else passes++;
    step();
    checks++;
    if (dir !== 4'b0100 || tick !== 1'b1)
      $display("FAIL down_commit got=%b t=%b exp=0100 t=1", dir, tick);
    else passes++;
    set_btn(4'b0001);
    wait_to(88);
    set_btn(4'b0000);
    wait_to(96);
    checks++;
    if (dir !== 4'b0001)
      $display("FAIL right_commit got=%b exp=0001", dir);
    else passes++;
  endtask

  task automatic test_reversal();
    set_btn(4'b0010);
    wait_to(104);
    set_btn(4'b0000);
    wait_to(112);
    checks++;
    if (dir !== 4'b0001)
      $display("FAIL reversal_t1 got=%b exp=0001", dir);
    else passes++;
    wait_to(128);
    checks++;
    if (dir !== 4'b0001)
      $display("FAIL reversal_t2 got=%b exp=0001", dir);
    else passes++;
    set_btn(4'b1000);
    wait_to(136);
    set_btn(4'b0000);
    wait_to(144);
    checks++;
    if (dir !== 4'b1000)
      $display("FAIL up_commit got=%b exp=1000", dir);
    else passes++;
  endtask

  task automatic test_priority();
    set_btn(4'b1010);
    wait_to(150);
    checks++;
    if (btn_pressed !== 4'b1010)
      $display("FAIL dual_level got=%b exp=1010", btn_pressed);
    else passes++;
    wait_to(152);
    set_btn(4'b0000);
    wait_to(160);
    checks++;
    if (dir !== 4'b1000)
      $display("FAIL prio_up_left got=%b exp=1000", dir);
    else passes++;
    set_btn(4'b0101);
    wait_to(168);
    set_btn(4'b0000);
    wait_to(176);
    checks++;
    if (dir !== 4'b1000)
      $display("FAIL prio_down_right got=%b exp=1000", dir);
    else passes++;
  endtask

  task automatic test_tick_edge();
    set_btn(4'b0001);
    wait_to(184);
    set_btn(4'b0000);
    wait_to(192);
    checks++;
    if (dir !== 4'b0001)
      $display("FAIL edge_setup got=%b exp=0001", dir);
    else passes++;
    wait_to(201);
    set_btn(4'b0100);
    wait_to(208);
    checks++;
    if (dir !== 4'b0001 || tick !== 1'b1)
      $display("FAIL edge_tick got=%b t=%b exp=0001 t=1", dir, tick);
    else passes++;
    wait_to(209);
    set_btn(4'b0000);
    wait_to(224);
    checks++;
    if (dir !== 4'b0100 || tick !== 1'b1)
      $display("FAIL edge_next got=%b t=%b exp=0100 t=1", dir, tick);
    else passes++;
  endtask

  task automatic test_reset_mid();
    set_btn(4'b1000);
    wait_to(227);
    reset = 1'b1;
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (n < 16) begin
      step();
      checks++;
      if (tick !== (n == 16) || clear_pulse !== (n == 13) ||
          btn_pressed !== 4'b0000)
        $display("FAIL mid_reset n=%0d got=%b%b btn=%b exp=%b%b btn=0000",
                 n, tick, clear_pulse, btn_pressed, (n == 16), (n == 13));
      else passes++;
    end
    checks++;
    if (dir !== 4'b0001)
      $display("FAIL mid_reset_dir got=%b exp=0001", dir);
    else passes++;
  endtask

`ifdef SNAKE_PAUSE_EN
  task automatic test_pause();
    pause_button = 1'b0;
    wait_to(22);
    checks++;
    if (paused !== 1'b0)
      $display("FAIL pause_early got=%b exp=0", paused);
    else passes++;
    step();
    checks++;
    if (paused !== 1'b1)
      $display("FAIL pause_on got=%b exp=1", paused);
    else passes++;
    wait_to(24);
    pause_button = 1'b1;
    while (n < 60) begin
      step();
      checks++;
      if (tick !== 1'b0 || clear_pulse !== 1'b0)
        $display("FAIL paused_quiet n=%0d got=%b%b exp=00", n,
                 tick, clear_pulse);
      else passes++;
    end
    pause_button = 1'b0;
    wait_to(66);
    checks++;
    if (paused !== 1'b1)
      $display("FAIL pause_hold got=%b exp=1", paused);
    else passes++;
    step();
    checks++;
    if (paused !== 1'b0)
      $display("FAIL pause_off got=%b exp=0", paused);
    else passes++;
    wait_to(68);
    pause_button = 1'b1;
    while (n < 80) begin
      step();
      checks++;
      if (tick !== (n == 76) || clear_pulse !== (n == 73))
        $display("FAIL resume n=%0d got=%b%b exp=%b%b", n, tick,
                 clear_pulse, (n == 76), (n == 73));
      else passes++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tick();
    test_debounce();
    test_reversal();
    test_priority();
    test_tick_edge();
    test_reset_mid();
`ifdef SNAKE_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
